// File: rtl/ex_stage_if.sv
// rtl/ex_stage_if.sv - ID/EX inputs and EX/MEM outputs of the execute stage
interface ex_stage_if #(
    parameter int WIDTH = 32
);
    logic             regWriteFlagInput;
    logic             MemReadFlagInput;
    logic             MemWriteFlagInput;
    logic             MemToRegInput;
    logic             ALUSrcInput;
    logic             BranchFlagInput;
    logic             JumpFlagInput;
    logic [3:0]       ALUControlInput;
    logic [WIDTH-1:0] IRInput;
    logic [WIDTH-1:0] ARegisterInput;
    logic [WIDTH-1:0] BRegisterInput;
    logic [WIDTH-1:0] BranchInput;
    logic [WIDTH-1:0] JumpInput;
    logic [4:0]       regDestAddressInput;

    logic             stallOut;
    logic             regWriteOut;
    logic             MemReadOut;
    logic             MemWriteOut;
    logic             MemToRegOut;
    logic [WIDTH-1:0] ALUResultOut;
    logic [WIDTH-1:0] storeDataOut;
    logic [4:0]       writeRegOut;
    logic             pcRedirectOut;
    logic [WIDTH-1:0] pcTargetOut;

    // Pipeline side: drives the ID/EX register, observes EX/MEM and control.
    modport master (
        output regWriteFlagInput, MemReadFlagInput, MemWriteFlagInput, MemToRegInput,
        output ALUSrcInput, BranchFlagInput, JumpFlagInput, ALUControlInput,
        output IRInput, ARegisterInput, BRegisterInput, BranchInput, JumpInput,
        output regDestAddressInput,
        input  stallOut, regWriteOut, MemReadOut, MemWriteOut, MemToRegOut,
        input  ALUResultOut, storeDataOut, writeRegOut, pcRedirectOut, pcTargetOut
    );

    // Execute stage side.
    modport slave (
        input  regWriteFlagInput, MemReadFlagInput, MemWriteFlagInput, MemToRegInput,
        input  ALUSrcInput, BranchFlagInput, JumpFlagInput, ALUControlInput,
        input  IRInput, ARegisterInput, BRegisterInput, BranchInput, JumpInput,
        input  regDestAddressInput,
        output stallOut, regWriteOut, MemReadOut, MemWriteOut, MemToRegOut,
        output ALUResultOut, storeDataOut, writeRegOut, pcRedirectOut, pcTargetOut
    );
endinterface

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - execute stage: ALU, branch resolution, iterative multiplier, EX/MEM register
module ex_stage #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    ex_stage_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [4:0]       r_cnt;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic             r_squash;

    logic             r_regwrite;
    logic             r_memread;
    logic             r_memwrite;
    logic             r_memtoreg;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_store;
    logic [4:0]       r_wreg;
    logic             r_redirect;
    logic [WIDTH-1:0] r_target;

    logic             w_live;
    logic             w_is_mul;
    logic             w_stall;
    logic             w_taken;
    logic [WIDTH-1:0] w_opb;
    logic [4:0]       w_shamt;
    logic [WIDTH-1:0] w_alu;
    logic             w_unused_ir;

    // The instruction right behind a taken transfer is a wrong-path bubble.
    assign w_live      = ~r_squash;
    assign w_opb       = bus.ALUSrcInput ? {{(WIDTH-16){bus.IRInput[15]}}, bus.IRInput[15:0]}
                                         : bus.BRegisterInput;
    assign w_shamt     = bus.IRInput[10:6];
    assign w_unused_ir = ^{bus.IRInput[WIDTH-1:16], bus.IRInput[5:0]};
    assign w_is_mul    = w_live && (bus.ALUControlInput == 4'b1100);
    // Gated by rst_n so a held MUL cannot raise the stall while in reset.
    assign w_stall     = rst_n && (((r_state == S_IDLE) && w_is_mul) || (r_state == S_MUL));
    // Only a retiring (non-stalled) instruction may redirect fetch.
    assign w_taken     = w_live && !w_stall &&
                         (bus.JumpFlagInput || (bus.BranchFlagInput &&
                                                (bus.ARegisterInput == bus.BRegisterInput)));

    // Single-cycle ALU result; MUL and unused codes yield zero here.
    always_comb begin
        w_alu = '0;
        case (bus.ALUControlInput)
            4'b0000: w_alu = bus.ARegisterInput & w_opb;
            4'b0001: w_alu = bus.ARegisterInput | w_opb;
            4'b0010: w_alu = bus.ARegisterInput + w_opb;
            4'b0011: w_alu = bus.ARegisterInput ^ w_opb;
            4'b0100: w_alu = ~(bus.ARegisterInput | w_opb);
            4'b0110: w_alu = bus.ARegisterInput - w_opb;
            4'b0111: w_alu = {{(WIDTH-1){1'b0}}, ($signed(bus.ARegisterInput) < $signed(w_opb))};
            4'b1000: w_alu = w_opb << w_shamt;
            4'b1001: w_alu = w_opb >> w_shamt;
            4'b1010: w_alu = $signed(w_opb) >>> w_shamt;
            default: w_alu = '0;
        endcase
    end

    // Multiplier FSM next state.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_is_mul) w_state_nxt = S_MUL;
            S_MUL:   if (r_cnt == 5'd31) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Multiplier FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Shift-add multiplier, LSB first; operands latched on entry so held inputs don't matter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if ((r_state == S_IDLE) && w_is_mul) begin
            r_mcand  <= bus.ARegisterInput;
            r_mplier <= w_opb;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (r_state == S_MUL) begin
            if (r_mplier[0]) r_acc <= r_acc + r_mcand;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 5'd1;
        end
    end

    // Redirect pulse, target and wrong-path squash flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_redirect <= 1'b0;
            r_target   <= '0;
            r_squash   <= 1'b0;
        end else begin
            r_redirect <= w_taken;
            r_squash   <= w_taken;
            if (w_taken) r_target <= bus.JumpFlagInput ? bus.JumpInput : bus.BranchInput;
        end
    end

    // EX/MEM register: bubble while stalled, otherwise load live controls and result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_regwrite <= 1'b0;
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
            r_memtoreg <= 1'b0;
            r_result   <= '0;
            r_store    <= '0;
            r_wreg     <= '0;
        end else if (w_stall) begin
            r_regwrite <= 1'b0;
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
            r_memtoreg <= 1'b0;
        end else begin
            r_regwrite <= bus.regWriteFlagInput & w_live;
            r_memread  <= bus.MemReadFlagInput  & w_live;
            r_memwrite <= bus.MemWriteFlagInput & w_live;
            r_memtoreg <= bus.MemToRegInput     & w_live;
            r_result   <= (r_state == S_DONE) ? r_acc : w_alu;
            r_store    <= bus.BRegisterInput;
            r_wreg     <= bus.regDestAddressInput;
        end
    end

    assign bus.stallOut      = w_stall;
    assign bus.regWriteOut   = r_regwrite;
    assign bus.MemReadOut    = r_memread;
    assign bus.MemWriteOut   = r_memwrite;
    assign bus.MemToRegOut   = r_memtoreg;
    assign bus.ALUResultOut  = r_result;
    assign bus.storeDataOut  = r_store;
    assign bus.writeRegOut   = r_wreg;
    assign bus.pcRedirectOut = r_redirect;
    assign bus.pcTargetOut   = r_target;
endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 5-stage pipeline. Consumes the ID/EX pipeline register outputs, performs ALU operations and branch/jump resolution, and loads the EX/MEM register. It holds a multi-cycle iterative multiplier and drives the `stallOut` back-pressure signal that gates the ID/EX load enable (`controlSignal = ~stallOut`). After a taken control transfer it issues a one-cycle PC redirect and squashes the wrong-path instruction behind it.

## Interface
- WIDTH, 32: datapath width (all data ports below are WIDTH bits)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- regWriteFlagInput, MemReadFlagInput, MemWriteFlagInput, MemToRegInput  in  1 each  control bits from ID/EX
- ALUSrcInput  in  1  1 = operand B is sign-extended IRInput[15:0]
- BranchFlagInput, JumpFlagInput  in  1 each  BEQ / unconditional jump
- ALUControlInput  in  4  operation code
- IRInput, ARegisterInput, BRegisterInput, BranchInput, JumpInput  in  32  instruction, rs value, rt value, branch target, jump target
- regDestAddressInput  in  5  resolved destination register
- stallOut  out  1  combinational; 1 = ID/EX must hold
- regWriteOut, MemReadOut, MemWriteOut, MemToRegOut  out  1 each  EX/MEM control
- ALUResultOut, storeDataOut  out  32  EX/MEM result, store data (B register)
- writeRegOut  out  5  EX/MEM destination
- pcRedirectOut  out  1  one-cycle pulse: fetch must load pcTargetOut
- pcTargetOut  out  32  redirect target

## Operation
- Operand B = ALUSrcInput ? {{16{IR[15]}}, IR[15:0]} : BRegisterInput. shamt = IR[10:6].
- ALUControl: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 NOR, 0110 SUB, 0111 SLT (signed, result 0/1), 1000 SLL B by shamt, 1001 SRL, 1010 SRA, 1100 MUL (low 32 bits of A*B, multi-cycle). All other codes → result 0. ADD/SUB wrap modulo 2^32; no overflow trap.
- Internal flag `squash` (registered). An instruction is *live* when squash=0. A non-live instruction is handled as a bubble: no EX/MEM control bits, no redirect, no MUL start.
- Taken = live && (JumpFlagInput || (BranchFlagInput && A==B)). Target = JumpFlagInput ? JumpInput : BranchInput (jump wins when both are set).
- On the edge that retires a taken instruction: pcRedirectOut<=1, pcTargetOut<=target, squash<=1. Otherwise pcRedirectOut<=0 and squash<=0.
- MUL FSM:
  - IDLE: a live MUL sets stallOut=1. At the edge: load the multiplicand and multiplier, clear the accumulator, cnt<=0, go to MUL.
  - MUL: stallOut=1. Each edge performs one shift-add step (LSB first) and cnt<=cnt+1. When cnt==31, go to DONE.
  - DONE: stallOut=0. The EX/MEM register captures the accumulator. Go to IDLE.
- stallOut = (IDLE && live MUL) || MUL. Outside those conditions it is 0.
- EX/MEM update at each edge:
  - If stallOut=1: insert a bubble (all four control bits 0). ALUResultOut, storeDataOut and writeRegOut hold.
  - Otherwise: load the control bits (ANDed with live), the result, storeDataOut<=BRegisterInput, and writeRegOut<=regDestAddressInput.
- Branches and jumps still forward their control bits (e.g. regWrite for a link), gated by live.

## Timing
- Reset (async assert, sync release): all outputs 0, FSM IDLE, cnt 0, squash 0, accumulator 0.
- Single-cycle ops: inputs present in cycle N, EX/MEM outputs valid after edge N+1.
- MUL: stallOut is high for 33 cycles (1 IDLE cycle + 32 MUL cycles). The DONE cycle has stallOut low and the result is registered at the end of that cycle, 34 cycles after the MUL arrived.
- The redirect pulse is high for exactly the cycle after the taken instruction's edge. The next ID/EX instruction (wrong path) is squashed in that same cycle.
- The instruction following a taken branch is squashed even if it is a branch or MUL: no stall and no redirect.
- reset mid-MUL: the FSM returns to IDLE immediately, stallOut=0, and the partial product is discarded.
- The MUL operands are latched at the IDLE→MUL edge, so input changes during the stall have no effect.

## Test plan
- Reset: hold rst_n=0 with arbitrary inputs → every output 0. Release → the first ADD A=5, B=7 gives ALUResultOut=12 one edge later.
- ALU sweep: SUB 3−5 → 0xFFFFFFFE; SLT −1<1 → 1; SRA 0x80000000 by shamt 4 → 0xF8000000; ALUSrc with IR[15:0]=0xFFFF, ADD A=1 → 0.
- MUL 0x10000 × 0x10003 → stallOut high for exactly 33 cycles, bubble EX/MEM during the stall, then ALUResultOut=0x00030000 with regWriteOut=1.
- BEQ A=B=9, target 0x40 → pcRedirectOut pulses 1 cycle with pcTargetOut=0x40. The following instruction (regWrite=1) produces regWriteOut=0. With A≠B → no redirect.
- Branch followed by MUL → the MUL is squashed, stallOut stays 0 and no result is written. A jump with the branch flag also set → target=JumpInput.
- Reset asserted at MUL cycle 10 → stallOut drops asynchronously. After release, a new MUL 3×4 → 12 with the full 33-cycle stall.
